// File: rtl/apb_master_ctrl_if.sv
// Command/response stream and APB bus signals of the APB master controller.
// The master modport is the controller's view; slave is the requester/fabric side.
interface apb_master_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic [2:0]        cmd_prot;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [2:0]        PPROT;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB3/APB4 master: one valid/ready command becomes one APB transfer, answered on a
// valid/ready response channel. Optional watchdog aborts transfers stuck in wait states.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_master_ctrl_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [2:0]        pprot_q, pprot_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= StIdle;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pprot_d  = bus.cmd_prot;
          // Reads drive no strobes and leave the last write data on PWDATA.
          if (bus.cmd_write) begin
            pwdata_d = bus.cmd_wdata;
            pstrb_d  = bus.cmd_strb;
          end else begin
            pstrb_d  = '0;
          end
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // PREADY wins over the watchdog when both fire on the same edge.
        if (bus.PREADY) begin
          rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          err_d     = bus.PSLVERR;
          timeout_d = 1'b0;
          state_d   = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready   = (state_q == StIdle) && !PRESET;
  assign bus.rsp_valid   = (state_q == StResp);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.PSEL        = (state_q == StSetup) || (state_q == StAccess);
  assign bus.PENABLE     = (state_q == StAccess);
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PPROT       = pprot_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Table-driven bench for apb_master_ctrl (TIMEOUT = 4) plus directed sequences for
// reset mid-transfer and response backpressure.
module tb_apb_master_ctrl;
  logic PCLK;
  logic PRESET;

  apb_master_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
    int          exp_pen;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_pwdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Latency counts edges from the accept edge (inclusive) to the edge raising rsp_valid.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    int pen;
    int k;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.cmd_prot  = v.prot;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = v.prdata;
    bus.PSLVERR   = v.slverr;
    chk({name, " cmd_ready idle"}, bus.cmd_ready, 1);
    @(posedge PCLK);
    lat = 1;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    chk({name, " setup psel"}, bus.PSEL, 1);
    chk({name, " setup penable"}, bus.PENABLE, 0);
    chk({name, " setup cmd_ready"}, bus.cmd_ready, 0);
    chk({name, " paddr"}, bus.PADDR, v.addr);
    chk({name, " pwrite"}, bus.PWRITE, v.wr);
    chk({name, " pprot"}, bus.PPROT, v.prot);
    pen = 0;
    k = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.PENABLE) begin
        pen++;
        chk({name, " access paddr"}, bus.PADDR, v.addr);
        chk({name, " access pwdata"}, bus.PWDATA, v.exp_pwdata);
        chk({name, " access pstrb"}, bus.PSTRB, v.exp_pstrb);
        bus.PREADY = (k >= v.waits);
        k++;
      end
      @(posedge PCLK);
      lat++;
      @(negedge PCLK);
    end
    bus.PREADY = 1'b0;
    chk({name, " latency"}, lat, v.exp_lat);
    chk({name, " penable cycles"}, pen, v.exp_pen);
    chk({name, " rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({name, " rsp_err"}, bus.rsp_err, v.exp_err);
    chk({name, " rsp_timeout"}, bus.rsp_timeout, v.exp_to);
    chk({name, " resp psel"}, bus.PSEL, 0);
    bus.rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    chk({name, " back to idle"}, bus.cmd_ready, 1);
    chk({name, " rsp_valid cleared"}, bus.rsp_valid, 0);
    chk({name, " paddr retained"}, bus.PADDR, v.addr);
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge PCLK);
      @(negedge PCLK);
      n++;
    end
    chk({name, " rsp_valid reached"}, bus.rsp_valid, 1);
  endtask

  initial begin
    // wr addr wdata strb prot waits slverr prdata | rdata err to lat pen pstrb pwdata
    vecs[0] = '{1'b1, 8'h04, 32'h12344321, 4'hF, 3'd0, 0, 1'b0, 32'hDEADBEEF,
                32'h0, 1'b0, 1'b0, 3, 1, 4'hF, 32'h12344321};
    vecs[1] = '{1'b0, 8'h04, 32'h0, 4'hF, 3'd2, 0, 1'b0, 32'h12344321,
                32'h12344321, 1'b0, 1'b0, 3, 1, 4'h0, 32'h12344321};
    vecs[2] = '{1'b1, 8'h10, 32'hA5A55A5A, 4'h5, 3'd1, 3, 1'b0, 32'h11111111,
                32'h0, 1'b0, 1'b0, 6, 4, 4'h5, 32'hA5A55A5A};
    vecs[3] = '{1'b0, 8'h02, 32'hFFFFFFFF, 4'hF, 3'd0, 0, 1'b1, 32'h0BADF00D,
                32'h0BADF00D, 1'b1, 1'b0, 3, 1, 4'h0, 32'hA5A55A5A};
    vecs[4] = '{1'b0, 8'h08, 32'h0, 4'h0, 3'd4, 99, 1'b0, 32'h55555555,
                32'h0, 1'b1, 1'b1, 7, 5, 4'h0, 32'hA5A55A5A};
    vecs[5] = '{1'b0, 8'h0C, 32'h0, 4'h0, 3'd0, 4, 1'b0, 32'h13572468,
                32'h13572468, 1'b0, 1'b0, 7, 5, 4'h0, 32'hA5A55A5A};
    vecs[6] = '{1'b1, 8'hFF, 32'h00FF00FF, 4'hC, 3'd7, 1, 1'b1, 32'h99999999,
                32'h0, 1'b1, 1'b0, 4, 2, 4'hC, 32'h00FF00FF};

    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    #2;
    chk("reset cmd_ready", bus.cmd_ready, 0);
    chk("reset psel", bus.PSEL, 0);
    chk("reset penable", bus.PENABLE, 0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset paddr", bus.PADDR, 0);
    chk("reset pwdata", bus.PWDATA, 0);
    chk("reset pstrb", bus.PSTRB, 0);
    chk("reset pprot", bus.PPROT, 0);
    chk("reset pwrite", bus.PWRITE, 0);
    chk("reset rsp_rdata", bus.rsp_rdata, 0);
    chk("reset rsp_err", bus.rsp_err, 0);
    chk("reset rsp_timeout", bus.rsp_timeout, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    chk("release cmd_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: response held 5 cycles while the next command waits.
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h20;
    bus.cmd_prot  = 3'd0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'h00000077;
    bus.PSLVERR   = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h30;
    bus.cmd_wdata = 32'hCAFE0001;
    bus.cmd_strb  = 4'h3;
    wait_rsp("bp first");
    bus.PRDATA  = '0;
    bus.PSLVERR = 1'b0;
    bus.PREADY  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp cmd_ready", bus.cmd_ready, 0);
      chk("bp rsp_valid", bus.rsp_valid, 1);
      chk("bp rsp_rdata", bus.rsp_rdata, 32'h77);
      chk("bp rsp_err", bus.rsp_err, 1);
      chk("bp paddr held", bus.PADDR, 8'h20);
      @(posedge PCLK);
      @(negedge PCLK);
    end
    bus.rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    chk("bp idle cmd_ready", bus.cmd_ready, 1);
    chk("bp idle rsp_valid", bus.rsp_valid, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    chk("bp next psel", bus.PSEL, 1);
    chk("bp next penable", bus.PENABLE, 0);
    chk("bp next paddr", bus.PADDR, 8'h30);
    chk("bp next pwrite", bus.PWRITE, 1);
    chk("bp next pstrb", bus.PSTRB, 4'h3);
    bus.PREADY = 1'b1;
    wait_rsp("bp second");
    chk("bp second rsp_err", bus.rsp_err, 0);
    chk("bp second rsp_rdata", bus.rsp_rdata, 0);
    bus.PREADY    = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;

    // Reset while in ACCESS: outputs drop asynchronously, no response afterwards.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h44;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("mid access penable", bus.PENABLE, 1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("mid reset psel", bus.PSEL, 0);
    chk("mid reset penable", bus.PENABLE, 0);
    chk("mid reset rsp_valid", bus.rsp_valid, 0);
    chk("mid reset cmd_ready", bus.cmd_ready, 0);
    chk("mid reset paddr", bus.PADDR, 0);
    @(negedge PCLK);
    PRESET     = 1'b0;
    bus.PREADY = 1'b1;
    #1;
    chk("post reset cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      chk("post reset no rsp", bus.rsp_valid, 0);
      chk("post reset no psel", bus.PSEL, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised, synthesizable APB master that turns a valid/ready command stream into APB3/APB4 transfers and returns a response through a valid/ready response channel. It sits between an on-chip requester (CPU bridge, DMA, test sequencer) and the APB slave fabric, and replaces the fixed-width, task-driven master. It adds configurable address and data widths, byte strobes, protection bits, slave-error capture, and a wait-state watchdog.

## Interface
Parameters:
- ADDR_W, default 8: PADDR and cmd_addr width, minimum 2.
- DATA_W, default 32: data width; must be 8, 16 or 32. STRB_W = DATA_W/8.
- TIMEOUT, default 16: maximum ACCESS cycles with PREADY low before abort. 0 disables the watchdog.

Ports (clock and reset first):
- PCLK  in  1  clock; all logic is rising-edge.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid and ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  STRB_W  write byte enables.
- cmd_prot  in  3  PPROT value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  out  1  transfer was aborted by the watchdog.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  STRB_W  APB strobes.
- PPROT  out  3  APB protection.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, register addr, write, wdata, strb and prot, then go to SETUP.
  - On a read, PSTRB is forced to 0 and PWDATA holds its previous value.
- SETUP: PSEL = 1 and PENABLE = 0 for exactly one cycle, then go to ACCESS.
- ACCESS: PSEL = 1 and PENABLE = 1. Address, control and data are stable for the whole phase.
  - PREADY = 1 at an edge: capture PRDATA (reads only; writes capture 0) and PSLVERR into the response registers, then go to RESP.
  - PREADY = 0: increment the wait counter (width $clog2(TIMEOUT+1)).
  - Wait counter reaches TIMEOUT (TIMEOUT > 0): set rsp_err = 1 and rsp_timeout = 1, set rsp_rdata = 0, then go to RESP.
- RESP:
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - Response registers hold until rsp_ready = 1, then go to IDLE and clear the wait counter.
  - No new command is accepted while in RESP: one outstanding transfer at a time.
- PSLVERR is ignored in every state except the ACCESS completion edge.
- PADDR, PWRITE, PWDATA and PPROT retain their last values outside a transfer and do not return to 0.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous) and the in-flight transfer is dropped with no response.

## Timing
- Reset values:
  - State IDLE.
  - cmd_ready = 1 once PRESET is released, 0 while it is asserted.
  - All other outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
- Zero-wait transfer, command accepted at edge N:
  - Edge N: SETUP visible.
  - Edge N+1: ACCESS visible.
  - Edge N+2: PREADY sampled high; RESP and rsp_valid visible.
  - Latency is 3 cycles from accept to rsp_valid. Each wait state adds 1.
- rsp_ready held high:
  - IDLE is reached 1 cycle after rsp_valid.
  - Minimum command-to-command spacing is 4 cycles.
- cmd_ready is combinational on state only; it never depends on cmd_valid.
- Timeout: with PREADY stuck low, rsp_valid rises TIMEOUT+1 cycles after ACCESS is entered.
- Watchdog boundary: PREADY rising on the same edge the counter hits TIMEOUT counts as a normal completion (rsp_timeout = 0).

## Test plan
- Reset: assert PRESET mid-ACCESS -> PSEL, PENABLE and rsp_valid drop to 0 asynchronously; cmd_ready is 1 after release; no response is issued.
- Zero-wait write addr 0x04, data 0x12344321, strb 0xF, then read 0x04 with the slave model returning the data -> PSEL/PENABLE phases last 1 cycle each; the read returns rsp_rdata = 0x12344321 with rsp_err = 0; the read shows PSTRB = 0.
- Write with 3 wait states, strb 0x5 -> PENABLE is high for 4 cycles with PADDR, PWDATA and PSTRB stable; rsp_valid appears 6 cycles after accept.
- Slave returns PSLVERR = 1 with PREADY on a read of 0x02 -> rsp_err = 1, rsp_timeout = 0, PRDATA is captured.
- TIMEOUT = 4 with PREADY stuck low -> abort after 4 ACCESS wait cycles; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- Boundary: PREADY rises on the same edge the counter reaches TIMEOUT -> normal completion with rsp_timeout = 0.
- Backpressure: rsp_ready held low for 5 cycles with cmd_valid high -> cmd_ready stays 0, the response stays stable, and the next command is accepted 1 cycle after the rsp_ready handshake.
